// File: rtl/tv80_bus_responder_if.sv
// -----------------------------------------------------------------------------
// tv80_bus_responder_if
//   Pin-level tv80s CPU bus bundle shared by the CPU (master) and the memory /
//   I/O responder (slave). All strobes are active low, as on the real Z80.
//
//   cpu_a       CPU address bus
//   cpu_do      CPU write data
//   cpu_di      CPU read data (driven by the responder)
//   cpu_mreq_n  memory request
//   cpu_iorq_n  I/O request
//   cpu_rd_n    read strobe
//   cpu_wr_n    write strobe
//   cpu_m1_n    opcode fetch / interrupt-acknowledge qualifier
//   cpu_rfsh_n  refresh qualifier
//   cpu_wait_n  wait request back to the CPU (driven by the responder)
// -----------------------------------------------------------------------------
interface tv80_bus_responder_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_m1_n;
  logic        cpu_rfsh_n;
  logic        cpu_wait_n;

  modport master (
    output cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
           cpu_m1_n, cpu_rfsh_n,
    input  cpu_di, cpu_wait_n
  );

  modport slave (
    input  cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
           cpu_m1_n, cpu_rfsh_n,
    output cpu_di, cpu_wait_n
  );
endinterface

// File: rtl/tv80_bus_responder.sv
// -----------------------------------------------------------------------------
// tv80_bus_responder
//   Memory + I/O responder sitting directly on the tv80s pins. Provides a
//   byte-wide memory of 2**ADDR_W cells (upper address bits alias), a 256-byte
//   I/O space, a write-protected ROM window below ROM_TOP, programmable wait
//   insertion for memory and I/O cycles, an IM2 vector on interrupt
//   acknowledge, and write/blocked-write counters for bench checks.
//
//   Data path and write side work on the falling edge of clk (mid T-state, as
//   the CPU expects); the wait generator works on the rising edge.
//
// Parameters
//   ADDR_W    memory address bits (depth = 2**ADDR_W)
//   ROM_TOP   writes to addresses below this are blocked (0 = no ROM)
//   MEM_WAIT  wait cycles per memory read/write access (0..15)
//   IO_WAIT   wait cycles per I/O read/write access (0..15)
//   IM2_VEC   byte returned during interrupt acknowledge
//
// Ports
//   clk           CPU clock (same clock as tv80s)
//   reset         asynchronous, active-high reset
//   bus           CPU bus, slave side
//   wr_cnt        accepted memory writes since reset (wraps)
//   wp_cnt        blocked ROM writes since reset (saturates at FF)
//   last_wr_addr  address of last accepted memory write
//   last_wr_data  data of last accepted memory write
// -----------------------------------------------------------------------------
module tv80_bus_responder #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] ROM_TOP  = 16'h0000,
  parameter int          MEM_WAIT = 0,
  parameter int          IO_WAIT  = 1,
  parameter logic [7:0]  IM2_VEC  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  tv80_bus_responder_if.slave  bus,
  output logic [15:0]          wr_cnt,
  output logic [7:0]           wp_cnt,
  output logic [15:0]          last_wr_addr,
  output logic [7:0]           last_wr_data
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N  = 4'(IO_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [7:0] mem [DEPTH];
  logic [7:0] io  [256];

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_idx;
  logic [7:0]        io_idx;
  logic              mem_acc;
  logic              io_acc;
  logic              iack;
  logic              mem_wr;
  logic              io_wr;
  logic              bus_idle;
  logic [16:0]       rom_diff;
  logic              in_rom;
  logic [3:0]        acc_n;

  assign mem_idx  = bus.cpu_a[ADDR_W-1:0];
  assign io_idx   = bus.cpu_a[7:0];

  // Refresh cycles have mreq_n low but rfsh_n low too; they are excluded here
  // so they neither read, write nor stall.
  assign mem_acc  = !bus.cpu_mreq_n && bus.cpu_rfsh_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
  assign io_acc   = !bus.cpu_iorq_n && bus.cpu_m1_n   && (!bus.cpu_rd_n || !bus.cpu_wr_n);
  assign iack     = !bus.cpu_iorq_n && !bus.cpu_m1_n;
  assign mem_wr   = !bus.cpu_wr_n && !bus.cpu_mreq_n && bus.cpu_rfsh_n;
  assign io_wr    = !bus.cpu_wr_n && !bus.cpu_iorq_n && bus.cpu_m1_n;
  assign bus_idle = bus.cpu_mreq_n && bus.cpu_iorq_n;

  // Borrow out of (cpu_a - ROM_TOP) means cpu_a < ROM_TOP. ROM_TOP = 0 never
  // borrows, so the window disappears without a special case.
  assign rom_diff = {1'b0, bus.cpu_a} - {1'b0, ROM_TOP};
  assign in_rom   = rom_diff[16];

  assign acc_n    = mem_acc ? MEM_N : IO_N;

  // ---------------------------------------------------------------------------
  // Array writes (falling edge)
  // ---------------------------------------------------------------------------
  // NOTE: the storage arrays have no reset; their contents survive reset and
  // the bench preloads them hierarchically. Resetting them would also stop
  // them mapping onto RAM primitives.
  always_ff @(negedge clk) begin
    if (mem_wr && !in_rom) begin
      mem[mem_idx] <= bus.cpu_do;
    end
    if (io_wr) begin
      io[io_idx] <= bus.cpu_do;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data, write bookkeeping (falling edge)
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q;
  logic [7:0] io_q;
  logic       wr_seen;

  // NOTE: sequential state is assigned with <= only, so every register in
  // this block samples the values from before the edge regardless of the
  // order of the statements.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      mem_q        <= 8'h00;
      io_q         <= 8'h00;
      wr_seen      <= 1'b0;
      wr_cnt       <= 16'h0000;
      wp_cnt       <= 8'h00;
      last_wr_addr <= 16'h0000;
      last_wr_data <= 8'h00;
    end else begin
      mem_q <= mem[mem_idx];
      io_q  <= io[io_idx];

      if (bus_idle) begin
        wr_seen <= 1'b0;
      end else if (mem_wr && !wr_seen) begin
        // A write M-cycle spans several falling edges; count it once.
        wr_seen <= 1'b1;
        if (in_rom) begin
          if (wp_cnt != 8'hFF) begin
            wp_cnt <= wp_cnt + 8'd1;
          end
        end else begin
          wr_cnt       <= wr_cnt + 16'd1;
          last_wr_addr <= bus.cpu_a;
          last_wr_data <= bus.cpu_do;
        end
      end
    end
  end

  // Interrupt acknowledge takes priority; otherwise the active request picks
  // the I/O or memory read register.
  assign bus.cpu_di = iack             ? IM2_VEC :
                      !bus.cpu_iorq_n  ? io_q    :
                                         mem_q;

  // ---------------------------------------------------------------------------
  // Wait generator (rising edge)
  // ---------------------------------------------------------------------------
  // cpu_wait_n drops on the rising edge that detects the access and stays low
  // for exactly N rising edges. HOLD parks the FSM until the request strobes
  // go away so a long access is never counted twice.
  state_t     state;
  logic [3:0] cnt;
  logic       wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      wait_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_acc || io_acc) begin
            if (acc_n != 4'd0) begin
              cnt    <= acc_n - 4'd1;
              state  <= ST_WAIT;
              wait_q <= 1'b0;
            end else begin
              cnt    <= 4'd0;
              state  <= ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          if (bus_idle) begin
            // CPU abandoned the cycle: release the bus immediately.
            state  <= ST_IDLE;
            wait_q <= 1'b1;
          end else if (cnt == 4'd0) begin
            state  <= ST_HOLD;
            wait_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus_idle) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          wait_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_wait_n = wait_q;

endmodule

// File: tb/tb_tv80_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_tv80_bus_responder
//   Emulates tv80s bus cycles against a responder built with a 4 KB aliased
//   memory, a ROM window below 0400h, 2 memory waits, 3 I/O waits and IM2
//   vector A5h. A flat array model supplies every expected value.
// -----------------------------------------------------------------------------
module tb_tv80_bus_responder;

  localparam int          ADDR_W   = 12;
  localparam logic [15:0] ROM_TOP  = 16'h0400;
  localparam int          MEM_WAIT = 2;
  localparam int          IO_WAIT  = 3;
  localparam logic [7:0]  IM2_VEC  = 8'hA5;
  localparam int          DEPTH    = 1 << ADDR_W;

  typedef enum int {K_MWR, K_MRD, K_IOWR, K_IORD, K_IACK} kind_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] wr_cnt;
  logic [7:0]  wp_cnt;
  logic [15:0] last_wr_addr;
  logic [7:0]  last_wr_data;

  tv80_bus_responder_if bus ();

  tv80_bus_responder #(
    .ADDR_W   (ADDR_W),
    .ROM_TOP  (ROM_TOP),
    .MEM_WAIT (MEM_WAIT),
    .IO_WAIT  (IO_WAIT),
    .IM2_VEC  (IM2_VEC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .wr_cnt       (wr_cnt),
    .wp_cnt       (wp_cnt),
    .last_wr_addr (last_wr_addr),
    .last_wr_data (last_wr_data)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  ref_io  [256];
  logic [15:0] ref_wr_cnt;
  logic [7:0]  ref_wp_cnt;
  logic [15:0] ref_last_addr;
  logic [7:0]  ref_last_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_rfsh_n = 1'b1;
  endtask

  // One bus cycle: strobes go up just after a rising edge, wait_n is sampled
  // 1 ns after each following rising edge until it reads high.
  task automatic access(input kind_t k, input logic [15:0] addr, input logic [7:0] data,
                        output logic [7:0] rdata, output int waits, output bit timeout);
    @(posedge clk); #1;
    bus.cpu_a  = addr;
    bus.cpu_do = data;
    case (k)
      K_MWR:   begin bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      K_MRD:   begin bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      K_IOWR:  begin bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
      K_IORD:  begin bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
      default: begin bus.cpu_iorq_n = 1'b0; bus.cpu_m1_n = 1'b0; end
    endcase
    waits   = 0;
    timeout = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (bus.cpu_wait_n === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      waits++;
    end
    rdata = bus.cpu_di;
    drive_idle();
  endtask

  task automatic run_op(input kind_t k, input logic [15:0] addr, input logic [7:0] data);
    logic [7:0] rd;
    int         w;
    bit         to;
    int         exp_w;
    access(k, addr, data, rd, w, to);
    check("wait_timeout", 32'(to), 32'd0);
    exp_w = (k == K_MWR || k == K_MRD) ? MEM_WAIT :
            (k == K_IACK)              ? 0        : IO_WAIT;
    check("wait_cycles", 32'(w), 32'(exp_w));
    case (k)
      K_MWR: begin
        if (addr < ROM_TOP) begin
          if (ref_wp_cnt != 8'hFF) ref_wp_cnt = ref_wp_cnt + 8'd1;
        end else begin
          ref_mem[addr % DEPTH] = data;
          ref_wr_cnt    = ref_wr_cnt + 16'd1;
          ref_last_addr = addr;
          ref_last_data = data;
        end
        check("wr_cnt", 32'(wr_cnt), 32'(ref_wr_cnt));
        check("wp_cnt", 32'(wp_cnt), 32'(ref_wp_cnt));
        check("last_wr_addr", 32'(last_wr_addr), 32'(ref_last_addr));
        check("last_wr_data", 32'(last_wr_data), 32'(ref_last_data));
      end
      K_MRD:  check("mem_read", 32'(rd), 32'(ref_mem[addr % DEPTH]));
      K_IOWR: ref_io[addr % 256] = data;
      K_IORD: check("io_read", 32'(rd), 32'(ref_io[addr % 256]));
      default: check("iack_vector", 32'(rd), 32'(IM2_VEC));
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    kind_t       k;
    logic [15:0] a;

    drive_idle();
    bus.cpu_a  = 16'h0000;
    bus.cpu_do = 8'h00;
    #1 reset = 1'b1;

    // Preload both arrays with random contents, mirrored in the model.
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = 8'($urandom);
      dut.mem[i]  = ref_mem[i];
    end
    for (int i = 0; i < 256; i++) begin
      ref_io[i]   = 8'($urandom);
      dut.io[i]   = ref_io[i];
    end
    ref_wr_cnt    = 16'h0000;
    ref_wp_cnt    = 8'h00;
    ref_last_addr = 16'h0000;
    ref_last_data = 8'h00;

    // Reset state
    #2;
    check("rst_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_wp_cnt", 32'(wp_cnt), 32'd0);
    check("rst_last_addr", 32'(last_wr_addr), 32'd0);
    check("rst_last_data", 32'(last_wr_data), 32'd0);
    check("rst_cpu_di", 32'(bus.cpu_di), 32'd0);
    #20 reset = 1'b0;

    // Aliased write then read-back through the low alias
    run_op(K_MWR, 16'h8123, 8'h5A);
    run_op(K_MRD, 16'h0123, 8'h00);
    run_op(K_MRD, 16'hF123, 8'h00);

    // ROM window edges: last blocked byte and first writable byte
    run_op(K_MWR, 16'h0100, 8'h77);
    run_op(K_MRD, 16'h0100, 8'h00);
    run_op(K_MWR, 16'h03FF, 8'hC3);
    run_op(K_MRD, 16'h03FF, 8'h00);
    run_op(K_MWR, 16'h0400, 8'h3C);
    run_op(K_MRD, 16'h0400, 8'h00);

    // I/O space: only the low address byte selects the port
    run_op(K_IOWR, 16'h0012, 8'h9C);
    run_op(K_IORD, 16'hAB12, 8'h00);

    // Interrupt acknowledge: vector, no waits
    run_op(K_IACK, 16'h0000, 8'h00);

    // Refresh with a write strobe: no waits, no write, no counting
    @(posedge clk); #1;
    bus.cpu_a      = 16'h8555;
    bus.cpu_do     = 8'hEE;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_rfsh_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rfsh_no_wait", 32'(bus.cpu_wait_n), 32'd1);
    end
    drive_idle();
    check("rfsh_wr_cnt", 32'(wr_cnt), 32'(ref_wr_cnt));
    run_op(K_MRD, 16'h0555, 8'h00);

    // Aborted cycle: strobes removed while waits are still pending
    @(posedge clk); #1;
    bus.cpu_a      = 16'h0600;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    @(posedge clk); #1;
    check("abort_wait_low", 32'(bus.cpu_wait_n), 32'd0);
    drive_idle();
    @(posedge clk); #1;
    check("abort_release", 32'(bus.cpu_wait_n), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      k = kind_t'($urandom_range(0, 4));
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 16'h03FF));
      run_op(k, a, 8'($urandom));
    end

    // Blocked-write counter saturation
    for (int n = 0; n < 260; n++) begin
      run_op(K_MWR, 16'($urandom_range(0, 16'h03FF)), 8'($urandom));
    end
    check("wp_saturated", 32'(wp_cnt), 32'hFF);

    // Reset in the middle of an I/O wait
    @(posedge clk); #1;
    bus.cpu_a      = 16'h0033;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    @(posedge clk); #1;
    check("midwait_low", 32'(bus.cpu_wait_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midwait_rst_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    check("midwait_rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("midwait_rst_wp_cnt", 32'(wp_cnt), 32'd0);
    check("midwait_rst_last_addr", 32'(last_wr_addr), 32'd0);
    ref_wr_cnt    = 16'h0000;
    ref_wp_cnt    = 8'h00;
    ref_last_addr = 16'h0000;
    ref_last_data = 8'h00;
    drive_idle();
    #3 reset = 1'b0;

    // Contents survive reset; FSM starts a fresh, full-length access
    run_op(K_MRD, 16'h0123, 8'h00);
    run_op(K_MRD, 16'h0400, 8'h00);
    run_op(K_IORD, 16'h0012, 8'h00);
    run_op(K_MWR, 16'h7ABC, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
